// File: rtl/sw_debounce_reader.sv
// Eight-switch reader: 2-flop synchronisers, per-bit debounce counters,
// registered LED mirror, change strobe and any-on flag.
module sw_debounce_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw0,
    input  logic sw1,
    input  logic sw2,
    input  logic sw3,
    input  logic sw4,
    input  logic sw5,
    input  logic sw6,
    input  logic sw7,
    output logic led0,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led5,
    output logic led6,
    output logic led7,
    output logic sw_change,
    output logic any_on
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sw_raw;
    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       stable_q;
    logic [7:0]       stable_d;
    logic [7:0]       update_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic             sw_change_q;
    logic             any_on_q;

    assign sw_raw = {sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};

    // Any agreement with the stable level clears progress toward an update.
    always_comb begin
        stable_d = stable_q;
        update_d = '0;
        for (int n = 0; n < 8; n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != stable_q[n]) begin
                if (cnt_q[n] == TERM) begin
                    stable_d[n] = sync2_q[n];
                    update_d[n] = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            sw_change_q <= 1'b0;
            any_on_q    <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync1_q     <= sw_raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            sw_change_q <= |update_d;
            any_on_q    <= |stable_d;
            for (int n = 0; n < 8; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign led0      = stable_q[0];
    assign led1      = stable_q[1];
    assign led2      = stable_q[2];
    assign led3      = stable_q[3];
    assign led4      = stable_q[4];
    assign led5      = stable_q[5];
    assign led6      = stable_q[6];
    assign led7      = stable_q[7];
    assign sw_change = sw_change_q;
    assign any_on    = any_on_q;

endmodule

// File: tb/tb_sw_debounce_reader.sv
// Directed bench for sw_debounce_reader with DEBOUNCE_CYCLES=4.
// Each scenario task drives switches and checks outputs #1 after each edge.
module tb_sw_debounce_reader;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic [7:0] led;
    logic       sw_change;
    logic       any_on;
    int         checks;
    int         failures;

    sw_debounce_reader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .sw0(sw[0]),
        .sw1(sw[1]),
        .sw2(sw[2]),
        .sw3(sw[3]),
        .sw4(sw[4]),
        .sw5(sw[5]),
        .sw6(sw[6]),
        .sw7(sw[7]),
        .led0(led[0]),
        .led1(led[1]),
        .led2(led[2]),
        .led3(led[3]),
        .led4(led[4]),
        .led5(led[5]),
        .led6(led[6]),
        .led7(led[7]),
        .sw_change(sw_change),
        .any_on(any_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({led, sw_change, any_on} !== 10'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got led=%h chg=%b on=%b want 0",
                         i, led, sw_change, any_on);
            end
        end
        sw = 8'h00;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({led, sw_change, any_on} !== 10'b0) begin
            failures++;
            $display("FAIL reset_idle: got led=%h chg=%b on=%b want 0",
                     led, sw_change, any_on);
        end
    endtask

    task automatic test_single();
        sw[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (led !== ((i >= 5) ? 8'h08 : 8'h00) ||
                sw_change !== (i == 5) || any_on !== (i >= 5)) begin
                failures++;
                $display("FAIL single_rise E0+%0d: got led=%h chg=%b on=%b",
                         i, led, sw_change, any_on);
            end
        end
        sw[3] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (led !== ((i >= 5) ? 8'h00 : 8'h08) ||
                sw_change !== (i == 5) || any_on !== (i < 5)) begin
                failures++;
                $display("FAIL single_fall E0+%0d: got led=%h chg=%b on=%b",
                         i, led, sw_change, any_on);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        sw[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(sw_change);
        end
        sw[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(sw_change);
            checks++;
            if (led !== 8'h00 || any_on !== 1'b0) begin
                failures++;
                $display("FAIL glitch_led cyc%0d: got led=%h on=%b want 0",
                         i, led, any_on);
            end
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL glitch_change: got %0d pulses want 0", pulses);
        end
        checks++;
        if (dut.cnt_q[0] !== '0) begin
            failures++;
            $display("FAIL glitch_cnt: got %0d want 0", dut.cnt_q[0]);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        sw[1] = 1'b1;
        sw[6] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(sw_change);
            checks++;
            if (led !== ((i >= 5) ? 8'h42 : 8'h00) ||
                sw_change !== (i == 5) || any_on !== (i >= 5)) begin
                failures++;
                $display("FAIL simul E0+%0d: got led=%h chg=%b on=%b",
                         i, led, sw_change, any_on);
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL simul_pulses: got %0d want 1", pulses);
        end
        sw[1] = 1'b0;
        sw[6] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (led !== 8'h00 || any_on !== 1'b0) begin
            failures++;
            $display("FAIL simul_clear: got led=%h on=%b want 0", led, any_on);
        end
    endtask

    task automatic test_reset_mid();
        sw[2] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (led !== 8'h00 || dut.cnt_q[2] !== '0) begin
            failures++;
            $display("FAIL rst_mid_clear: got led=%h cnt=%0d want 0",
                     led, dut.cnt_q[2]);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (led !== ((i >= 5) ? 8'h04 : 8'h00) || sw_change !== (i == 5)) begin
                failures++;
                $display("FAIL rst_mid E0+%0d: got led=%h chg=%b",
                         i, led, sw_change);
            end
        end
        sw[2] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            sw[5] = (k % 2 == 0);
            tick();
            checks++;
            if (led !== 8'h00 || sw_change !== 1'b0) begin
                failures++;
                $display("FAIL bounce cyc%0d: got led=%h chg=%b want 0",
                         k, led, sw_change);
            end
        end
        sw[5] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (led !== ((i >= 5) ? 8'h20 : 8'h00) || sw_change !== (i == 5)) begin
                failures++;
                $display("FAIL bounce_settle E0+%0d: got led=%h chg=%b",
                         i, led, sw_change);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sw       = 8'h00;
        test_reset();
        test_single();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_bounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
